fll_cfg_master: RTL
===================

Name: fll_cfg_master

Overview:
Initiator side of the FLL configuration interface. It converts single-beat commands from the SoC control register file into the 4-phase req/ack handshake used by FLL config slaves, whether real FLL macro or dummy model. It captures read data, reports timeouts, and monitors the FLL lock signal. There is one instance per FLL (soc, per, cluster), placed next to each FLL in the clock/reset generation block.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for each ack edge before aborting; legal range 1..65535.
LOCK_CNT_W, 8, width of the saturating lock-loss counter.

Ports:
fll_cfg_clk  in  1  config clock
rstn_glob_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted this cycle when valid & ready
cmd_wrn_i  in  1  1 = read, 0 = write (same polarity as slave wrn)
cmd_add_i  in  2  FLL register address
cmd_data_i  in  32  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  32  read data (0 for writes and errors)
rsp_err_o  out  1  transaction timed out
fll_req_o  out  1  to slave req
fll_wrn_o  out  1  to slave wrn
fll_add_o  out  2  to slave add
fll_data_o  out  32  to slave data
fll_ack_i  in  1  from slave ack
fll_r_data_i  in  32  from slave read data
fll_lock_i  in  1  raw lock from FLL (asynchronous)
lock_o  out  1  synchronized lock
lock_lost_cnt_o  out  LOCK_CNT_W  number of lock falling edges
lock_cnt_clr_i  in  1  synchronous clear of lock_lost_cnt_o

Behaviour:
- Clock is fll_cfg_clk. Reset is rstn_glob_i, asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. cmd_ready_o becomes 1 on the first cycle after reset release.
- FSM states: IDLE, REQ, ACK_LOW, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, register wrn/add/data onto the fll_* outputs, set fll_req_o = 1 on the next edge, clear the timer, and go to REQ.
- REQ:
  - fll_req_o stays high; fll_wrn/add/data are held stable.
  - Ack handling (fll_ack_i == 1):
    - Drop fll_req_o.
    - For a read, capture fll_r_data_i into rsp_rdata_o.
    - Clear the timer and go to ACK_LOW.
  - Timeout (timer == TIMEOUT_CYCLES-1 with no ack):
    - Drop fll_req_o, set rsp_err_o = 1, rsp_rdata_o = 0.
    - Go to ACK_LOW with the timer cleared.
- ACK_LOW:
  - Wait for fll_ack_i == 0, then go to RESP.
  - On timeout, set rsp_err_o = 1 and go to RESP anyway.
- RESP:
  - rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are held until rsp_ready_i.
  - On rsp_ready_i, go to IDLE and clear rsp_valid_o and rsp_err_o.
  - rsp_valid_o never drops without rsp_ready_i.
- Latency against an ack-after-1-cycle slave:
  - cmd accept at cycle 0, req high at cycle 1, ack seen at cycle 2.
  - req low at cycle 3, ack low seen at cycle 3 or 4.
  - rsp_valid_o no later than cycle 5.
- Timer width is clog2(TIMEOUT_CYCLES+1). The timer does not wrap; it stops at its limit.
- Only one transaction is outstanding. cmd_ready_o = 0 in every state except IDLE.
- Ack already high when entering REQ (stale): treated as a valid ack. This is legal only if the previous ACK_LOW timed out; the error is already reported.
- Lock path:
  - 2-flop synchronizer on fll_lock_i; output is lock_o.
  - A falling edge of lock_o increments lock_lost_cnt_o. The counter saturates at all-ones.
  - lock_cnt_clr_i has priority over an increment in the same cycle.
  - Lock monitoring runs independently of the FSM.
- Reset mid-transaction: everything returns to reset values immediately; fll_req_o drops asynchronously. No response is generated for the aborted command.

Optional Feature:
FLL_CFG_MST_LOCK_WAIT_EN
- Defined:
  - Adds state LOCK_WAIT between ACK_LOW and RESP, entered only for successful writes to address 2'b01 (the FLL config register).
  - It waits for lock_o == 1, bounded by TIMEOUT_CYCLES.
  - On lock timeout, rsp_err_o = 1.
- Undefined: no LOCK_WAIT state. Writes to address 1 respond as soon as ACK_LOW completes.

Test Plan:
1. Write add=1, data=0xC0DE_0001, slave acks one cycle after req, rsp_ready tied 1 -> fll_req high for exactly 2 cycles, data/add stable while req high, rsp_valid by cycle 5, rsp_err=0, rsp_rdata=0.
2. Read add=2, slave returns 0xDEADBEAF with ack -> rsp_rdata=0xDEADBEAF, rsp_err=0; a second command while rsp_valid is pending sees cmd_ready=0.
3. TIMEOUT_CYCLES=16, slave never acks -> fll_req drops after 16 cycles, rsp_err=1, rsp_rdata=0, FSM returns to IDLE after rsp_ready.
4. rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid, rdata and err stay constant; accept occurs on the cycle rsp_ready=1.
5. fll_lock_i toggles 1→0→1 three times, then lock_cnt_clr_i pulses coincident with a fourth fall -> lock_o lags by 2 cycles, count reaches 3, then reads 0 after the clear; a LOCK_CNT_W=2 run saturates at 3.
6. rstn_glob_i asserted while in REQ -> fll_req_o=0 immediately, no rsp_valid after release, cmd_ready=1 next cycle; with FLL_CFG_MST_LOCK_WAIT_EN and lock held 0, a write to add=1 returns rsp_err=1 after the lock timeout.

Source files
------------

// File: rtl/fll_cfg_master.sv
// FLL config initiator: turns single-beat commands into the 4-phase req/ack handshake, synchronizes lock.
// Optional build macro FLL_CFG_MST_LOCK_WAIT_EN adds a LOCK_WAIT state after writes to the config register.
module fll_cfg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned LOCK_CNT_W     = 8
) (
    input  logic                  fll_cfg_clk,
    input  logic                  rstn_glob_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wrn_i,
    input  logic [1:0]            cmd_add_i,
    input  logic [31:0]           cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  fll_req_o,
    output logic                  fll_wrn_o,
    output logic [1:0]            fll_add_o,
    output logic [31:0]           fll_data_o,
    input  logic                  fll_ack_i,
    input  logic [31:0]           fll_r_data_i,
    input  logic                  fll_lock_i,
    output logic                  lock_o,
    output logic [LOCK_CNT_W-1:0] lock_lost_cnt_o,
    input  logic                  lock_cnt_clr_i
);

    localparam int unsigned ADD_W  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
`ifdef FLL_CFG_MST_LOCK_WAIT_EN
    localparam logic [ADD_W-1:0] CFG_ADD = ADD_W'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_ACK_LOW   = 3'd2,
        S_RESP      = 3'd3
`ifdef FLL_CFG_MST_LOCK_WAIT_EN
        , S_LOCK_WAIT = 3'd4
`endif
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic                r_cmd_ready;
    logic                w_cmd_ready_nxt;
    logic                r_rsp_valid;
    logic                w_rsp_valid_nxt;
    logic                r_rsp_err;
    logic                w_rsp_err_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                r_fll_req;
    logic                w_fll_req_nxt;
    logic                r_fll_wrn;
    logic                w_fll_wrn_nxt;
    logic [ADD_W-1:0]    r_fll_add;
    logic [ADD_W-1:0]    w_fll_add_nxt;
    logic [DATA_W-1:0]   r_fll_data;
    logic [DATA_W-1:0]   w_fll_data_nxt;

    logic                r_lock_meta;
    logic                r_lock_sync;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;

    logic                w_accept;
    logic                w_timeout;
    logic                w_waiting;
    logic                w_lock_fall;
    logic                w_lock_wait_go;

    // r_cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier
    assign w_accept  = cmd_valid_i & r_cmd_ready;
    assign w_timeout = (r_timer == TMR_LAST);
    assign w_waiting = (r_state != S_IDLE) && (r_state != S_RESP);

`ifdef FLL_CFG_MST_LOCK_WAIT_EN
    assign w_lock_wait_go = !fll_ack_i && !r_rsp_err && !r_fll_wrn && (r_fll_add == CFG_ADD);
`else
    assign w_lock_wait_go = 1'b0;
`endif

    // State and FSM-owned output registers
    always_ff @(posedge fll_cfg_clk or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_fll_req   <= 1'b0;
            r_fll_wrn   <= 1'b0;
            r_fll_add   <= '0;
            r_fll_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_fll_req   <= w_fll_req_nxt;
            r_fll_wrn   <= w_fll_wrn_nxt;
            r_fll_add   <= w_fll_add_nxt;
            r_fll_data  <= w_fll_data_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (fll_ack_i || w_timeout) begin
                    w_state_nxt = S_ACK_LOW;
                end
            end
            S_ACK_LOW: begin
                if (!fll_ack_i || w_timeout) begin
`ifdef FLL_CFG_MST_LOCK_WAIT_EN
                    w_state_nxt = w_lock_wait_go ? S_LOCK_WAIT : S_RESP;
`else
                    w_state_nxt = S_RESP;
`endif
                end
            end
`ifdef FLL_CFG_MST_LOCK_WAIT_EN
            S_LOCK_WAIT: begin
                if (r_lock_sync || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of registered outputs and the wait timer
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_fll_req_nxt   = r_fll_req;
        w_fll_wrn_nxt   = r_fll_wrn;
        w_fll_add_nxt   = r_fll_add;
        w_fll_data_nxt  = r_fll_data;
        w_timer_nxt     = '0;

        // Timer runs only while parked in a wait state and saturates at the timeout value
        if (w_waiting && (w_state_nxt == r_state)) begin
            w_timer_nxt = w_timeout ? r_timer : r_timer + TMR_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_fll_req_nxt   = 1'b1;
                    w_fll_wrn_nxt   = cmd_wrn_i;
                    w_fll_add_nxt   = cmd_add_i;
                    w_fll_data_nxt  = cmd_data_i;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            S_REQ: begin
                if (fll_ack_i) begin
                    w_fll_req_nxt = 1'b0;
                    if (r_fll_wrn) begin
                        w_rsp_rdata_nxt = fll_r_data_i;
                    end
                end else if (w_timeout) begin
                    w_fll_req_nxt   = 1'b0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_ACK_LOW: begin
                if (fll_ack_i && w_timeout) begin
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
`ifdef FLL_CFG_MST_LOCK_WAIT_EN
            S_LOCK_WAIT: begin
                if (!r_lock_sync && w_timeout) begin
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_err_nxt = 1'b0;
                end
            end
            default: begin
                w_fll_req_nxt = 1'b0;
            end
        endcase
    end

    // Lock synchronizer and saturating lock-loss counter, independent of the FSM
    assign w_lock_fall = r_lock_sync & ~r_lock_meta;

    always_ff @(posedge fll_cfg_clk or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_lock_cnt  <= '0;
        end else begin
            r_lock_meta <= fll_lock_i;
            r_lock_sync <= r_lock_meta;
            if (lock_cnt_clr_i) begin
                r_lock_cnt <= '0;
            end else if (w_lock_fall && (r_lock_cnt != '1)) begin
                r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
            end
        end
    end

    assign cmd_ready_o     = r_cmd_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_err_o       = r_rsp_err;
    assign rsp_rdata_o     = r_rsp_rdata;
    assign fll_req_o       = r_fll_req;
    assign fll_wrn_o       = r_fll_wrn;
    assign fll_add_o       = r_fll_add;
    assign fll_data_o      = r_fll_data;
    assign lock_o          = r_lock_sync;
    assign lock_lost_cnt_o = r_lock_cnt;

endmodule
